// File: rtl/sw_debounce.sv
// Switch input conditioner: per-bit synchronizer plus bounce filter feeding the switch device.
// Optional macro SW_DEBOUNCE_EDGE_EN adds registered per-bit rise/fall strobes (sw_rise/sw_fall).
module sw_debounce #(
  parameter int NBITS           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNTBITS         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] sw_raw,
  output logic [NBITS-1:0] sw_db,
  output logic             sw_changed
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall
`endif
);

  localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    COUNTING
  } bit_state_e;

  logic [NBITS-1:0]   sync_q [SYNC_STAGES];
  logic [NBITS-1:0]   sync;
  logic [CNTBITS-1:0] cnt_q  [NBITS];
  logic [CNTBITS-1:0] cnt_d  [NBITS];
  bit_state_e         state  [NBITS];
  logic [NBITS-1:0]   upd;

  // The first stage samples the pins directly; no logic in front of it.
  // NOTE: state elements use <= so every flop samples pre-edge values and the chain shifts by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < NBITS; i++) begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      cnt_d[i] = '0;
      upd[i]   = 1'b0;
      state[i] = (sync[i] != sw_db[i]) ? COUNTING : STABLE;
      case (state[i])
        STABLE:   cnt_d[i] = '0;
        COUNTING: begin
          if (cnt_q[i] == CNT_MAX) upd[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + CNTBITS'(1);
        end
        default:  cnt_d[i] = '0;
      endcase
    end
  end

  // NOTE: counters are individual flops, not a RAM, so resetting them all is cheap and
  // guarantees any count in progress at reset is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
      sw_db      <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < NBITS; i++) cnt_q[i] <= cnt_d[i];
      sw_db      <= (sw_db & ~upd) | (sync & upd);
      sw_changed <= |upd;
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Strobes register alongside sw_db, so they line up with sw_changed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= upd & sync;
      sw_fall <= upd & ~sync;
    end
  end
`else
  // No edge strobes: upd feeds only sw_db and sw_changed.
`endif

endmodule
